trig_seq_ctrl: RTL and testbench

TRIG_SEQ_CTRL -- requirements
Module: trig_seq_ctrl

---
 rtl/trig_ctrl_pkg.sv | 33 +++
 rtl/trig_edge_sync.sv | 36 +++
 rtl/trig_seq_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_trig_seq_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_ctrl_pkg.sv
// Shared definitions for the trigger sequencer: FSM encoding, default
// widths and the reset values of the configuration shadow registers.
package trig_ctrl_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned PER_W_DEF = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_PULSE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } trig_state_e;

  localparam int unsigned SHD_PERIOD_RST = 1000;
  localparam logic [7:0]  SHD_WIDTH_RST  = 8'd1;
  localparam int unsigned SHD_COUNT_RST  = 1;
  localparam logic        SHD_SRC_RST    = 1'b0;
  localparam logic        SRC_EXT        = 1'b1;

  // A programmed width of zero still produces a one-clock pulse.
  function automatic logic [7:0] eff_width(input logic [7:0] width);
    logic [7:0] w;
    if (width == 8'd0) begin
      w = 8'd1;
    end else begin
      w = width;
    end
    return w;
  endfunction

endpackage

// File: rtl/trig_edge_sync.sv
// Two-flop synchronizer for the asynchronous external trigger followed by
// an edge-history flop; rise_o is high for one clock per rising edge.
module trig_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Next values of the synchronizer chain and the edge history.
  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchronizer and edge-history flops, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/trig_seq_ctrl.sv
// Trigger sequencer: issues a run of fixed-width trigger pulses, either
// on an internal period or on synchronized external edges, gated by the
// idle flags of the downstream delay channels.
module trig_seq_ctrl
  import trig_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned PER_W = PER_W_DEF
) (
  input  logic             I_clk_250mhz,
  input  logic             I_rst_n,
  input  logic             I_cfg_wr,
  input  logic [PER_W-1:0] I_cfg_period,
  input  logic [7:0]       I_cfg_width,
  input  logic [CNT_W-1:0] I_cfg_count,
  input  logic             I_cfg_src,
  input  logic             I_start,
  input  logic             I_stop,
  input  logic             I_ext_trig,
  input  logic [3:0]       I_ch_idle,
  output logic             O_trig,
  output logic             O_busy,
  output logic             O_done,
  output logic             O_cfg_err,
  output logic             O_overrun,
  output logic [CNT_W-1:0] O_trig_cnt,
  output logic [2:0]       O_state
);

  trig_state_e      state_q, state_d;
  logic [PER_W-1:0] period_q, period_d;
  logic [7:0]       width_q, width_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             src_q, src_d;
  logic [PER_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] trig_cnt_q, trig_cnt_d;
  logic             overrun_q, overrun_d;
  logic             cfg_err_q, cfg_err_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             trig_q, trig_d;

  logic             ext_rise_s;
  logic             all_idle_s;
  logic             pulse_last_s;
  logic             gap_last_s;
  logic             start_ok_s;
  logic [PER_W-1:0] cur_ew_s;
  logic [PER_W-1:0] nxt_ew_s;

  trig_edge_sync u_edge_sync (
    .clk     (I_clk_250mhz),
    .rst_n   (I_rst_n),
    .async_i (I_ext_trig),
    .rise_o  (ext_rise_s)
  );

  // Decode the conditions the sequencer reacts to. A start issued together
  // with a config write is validated against the values being written, so
  // a run can never begin with an inconsistent configuration.
  always_comb begin
    all_idle_s   = (I_ch_idle == 4'hF);
    cur_ew_s     = PER_W'(eff_width(width_q));
    pulse_last_s = (pcnt_q == (cur_ew_s - PER_W'(1)));
    gap_last_s   = (pcnt_q == (period_q - PER_W'(1)));
    if (I_cfg_wr) begin
      nxt_ew_s   = PER_W'(eff_width(I_cfg_width));
      start_ok_s = I_cfg_src | (I_cfg_period > nxt_ew_s);
    end else begin
      nxt_ew_s   = cur_ew_s;
      start_ok_s = src_q | (period_q > cur_ew_s);
    end
  end

  // Next-state, shadow, counter and output computation.
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    width_d    = width_q;
    count_d    = count_q;
    src_d      = src_q;
    pcnt_d     = pcnt_q;
    trig_cnt_d = trig_cnt_q;
    overrun_d  = overrun_q;
    cfg_err_d  = 1'b0;

    if (I_stop && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (I_cfg_wr) begin
            period_d = I_cfg_period;
            width_d  = I_cfg_width;
            count_d  = I_cfg_count;
            src_d    = I_cfg_src;
          end else begin
            period_d = period_q;
          end
          if (I_start && !I_stop) begin
            if (start_ok_s) begin
              state_d    = ST_ARM;
              trig_cnt_d = {CNT_W{1'b0}};
              overrun_d  = 1'b0;
            end else begin
              cfg_err_d  = 1'b1;
            end
          end else begin
            cfg_err_d = 1'b0;
          end
        end
        ST_ARM: begin
          // An external edge seen while a channel is busy is simply lost.
          if (all_idle_s && ((src_q != SRC_EXT) || ext_rise_s)) begin
            state_d = ST_PULSE;
          end else begin
            state_d = ST_ARM;
          end
        end
        ST_PULSE: begin
          pcnt_d = pcnt_q + PER_W'(1);
          if (pulse_last_s) begin
            if ((count_q != {CNT_W{1'b0}}) && (trig_cnt_q == count_q)) begin
              state_d = ST_DONE;
            end else if (src_q == SRC_EXT) begin
              state_d = ST_ARM;
            end else begin
              state_d = ST_GAP;
            end
          end else begin
            state_d = ST_PULSE;
          end
        end
        ST_GAP: begin
          pcnt_d = pcnt_q + PER_W'(1);
          if (gap_last_s) begin
            if (all_idle_s) begin
              state_d = ST_PULSE;
            end else begin
              // Slot missed: flag it and wait for the channels in ARM.
              overrun_d = 1'b1;
              state_d   = ST_ARM;
            end
          end else begin
            state_d = ST_GAP;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Entering PULSE restarts the period counter and counts the trigger.
    if ((state_d == ST_PULSE) && (state_q != ST_PULSE)) begin
      pcnt_d = {PER_W{1'b0}};
      if (trig_cnt_q != {CNT_W{1'b1}}) begin
        trig_cnt_d = trig_cnt_q + CNT_W'(1);
      end else begin
        trig_cnt_d = trig_cnt_q;
      end
    end else if ((state_d != ST_PULSE) && (state_d != ST_GAP)) begin
      pcnt_d = {PER_W{1'b0}};
    end else begin
      trig_cnt_d = trig_cnt_d;
    end

    trig_d = (state_d == ST_PULSE);
    done_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_ARM) || (state_d == ST_PULSE) || (state_d == ST_GAP);
  end

  // Registers; reset clears everything and reloads the default shadows.
  always_ff @(posedge I_clk_250mhz or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q    <= ST_IDLE;
      period_q   <= PER_W'(SHD_PERIOD_RST);
      width_q    <= SHD_WIDTH_RST;
      count_q    <= CNT_W'(SHD_COUNT_RST);
      src_q      <= SHD_SRC_RST;
      pcnt_q     <= {PER_W{1'b0}};
      trig_cnt_q <= {CNT_W{1'b0}};
      overrun_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      trig_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      width_q    <= width_d;
      count_q    <= count_d;
      src_q      <= src_d;
      pcnt_q     <= pcnt_d;
      trig_cnt_q <= trig_cnt_d;
      overrun_q  <= overrun_d;
      cfg_err_q  <= cfg_err_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      trig_q     <= trig_d;
    end
  end

  assign O_trig     = trig_q;
  assign O_busy     = busy_q;
  assign O_done     = done_q;
  assign O_cfg_err  = cfg_err_q;
  assign O_overrun  = overrun_q;
  assign O_trig_cnt = trig_cnt_q;
  assign O_state    = state_q;

endmodule

// File: tb/tb_trig_seq_ctrl.sv
// Self-checking bench for trig_seq_ctrl: a cycle-level behavioural model
// compared against the DUT every clock, directed scenarios with
// hand-computed timing, then randomized traffic.
module tb_trig_seq_ctrl;

  localparam int CNT_W   = 16;
  localparam int PER_W   = 24;
  localparam int CNT_MAX = 65535;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             I_cfg_wr = 1'b0;
  logic [PER_W-1:0] I_cfg_period = '0;
  logic [7:0]       I_cfg_width = '0;
  logic [CNT_W-1:0] I_cfg_count = '0;
  logic             I_cfg_src = 1'b0;
  logic             I_start = 1'b0;
  logic             I_stop = 1'b0;
  logic             I_ext_trig = 1'b0;
  logic [3:0]       I_ch_idle = 4'hF;
  logic             O_trig, O_busy, O_done, O_cfg_err, O_overrun;
  logic [CNT_W-1:0] O_trig_cnt;
  logic [2:0]       O_state;

  trig_seq_ctrl dut (
    .I_clk_250mhz (clk),
    .I_rst_n      (rst_n),
    .I_cfg_wr     (I_cfg_wr),
    .I_cfg_period (I_cfg_period),
    .I_cfg_width  (I_cfg_width),
    .I_cfg_count  (I_cfg_count),
    .I_cfg_src    (I_cfg_src),
    .I_start      (I_start),
    .I_stop       (I_stop),
    .I_ext_trig   (I_ext_trig),
    .I_ch_idle    (I_ch_idle),
    .O_trig       (O_trig),
    .O_busy       (O_busy),
    .O_done       (O_done),
    .O_cfg_err    (O_cfg_err),
    .O_overrun    (O_overrun),
    .O_trig_cnt   (O_trig_cnt),
    .O_state      (O_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Clock-edge counter used to time directed expectations.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- behavioural model ----------------
  // Phase numbers are the documented debug state values.
  int m_ph, m_t, m_cnt, m_period, m_width, m_count, m_src;
  bit m_over, m_err;
  bit p1, p2, p3;   // external pin sampled 1, 2, 3 edges ago

  task automatic model_reset();
    m_ph = 0; m_t = 0; m_cnt = 0; m_over = 0; m_err = 0;
    m_period = 1000; m_width = 1; m_count = 1; m_src = 0;
    p1 = 0; p2 = 0; p3 = 0;
  endtask

  task automatic model_step();
    bit flag, idle_ok, fire;
    int ew;
    flag = p2 && !p3;
    p3 = p2; p2 = p1; p1 = I_ext_trig;
    idle_ok = (I_ch_idle == 4'hF);
    fire = 0;
    m_err = 0;
    if (m_ph != 0 && I_stop) begin
      m_ph = 0;
    end else begin
      if (m_ph == 0) begin
        if (I_cfg_wr) begin
          m_period = int'(I_cfg_period);
          m_width  = int'(I_cfg_width);
          m_count  = int'(I_cfg_count);
          m_src    = int'(I_cfg_src);
        end
      end
      ew = (m_width == 0) ? 1 : m_width;
      case (m_ph)
        0: if (I_start && !I_stop) begin
             if (m_src == 1 || m_period > ew) begin m_ph = 1; m_cnt = 0; m_over = 0; end
             else m_err = 1;
           end
        1: if (idle_ok && (m_src == 0 || flag)) fire = 1;
        2: begin
             m_t++;
             if (m_t == ew) begin
               if (m_count != 0 && m_cnt == m_count) m_ph = 4;
               else if (m_src == 1) m_ph = 1;
               else m_ph = 3;
             end
           end
        3: begin
             m_t++;
             if (m_t == m_period) begin
               if (idle_ok) fire = 1;
               else begin m_over = 1; m_ph = 1; end
             end
           end
        default: m_ph = 0;
      endcase
    end
    if (fire) begin
      m_ph = 2; m_t = 0;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  // Advance the model on every clock edge, or clear it on reset.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare every DUT output against the model once per cycle.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("trig",     O_trig,     (m_ph == 2) ? 1 : 0);
      chk("busy",     O_busy,     (m_ph >= 1 && m_ph <= 3) ? 1 : 0);
      chk("done",     O_done,     (m_ph == 4) ? 1 : 0);
      chk("cfg_err",  O_cfg_err,  m_err);
      chk("overrun",  O_overrun,  m_over);
      chk("trig_cnt", O_trig_cnt, m_cnt);
      chk("state",    O_state,    m_ph);
    end
  end

  // ---------------- event monitor for directed checks ----------------
  int rises[$];
  int widths[$];
  int done_cnt, err_cnt, busy_seen, done_cyc;
  bit trig_prev;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (O_trig && !trig_prev) rises.push_back(cyc);
      if (!O_trig && trig_prev && rises.size() > 0) widths.push_back(cyc - rises[rises.size()-1]);
      if (O_done) begin done_cnt++; done_cyc = cyc; end
      if (O_cfg_err) err_cnt++;
      if (O_busy) busy_seen++;
      trig_prev = O_trig;
    end else begin
      trig_prev = 1'b0;
    end
  end

  function automatic int rise_at(input int i);
    if (i < rises.size()) return rises[i];
    return -1;
  endfunction

  function automatic int width_at(input int i);
    if (i < widths.size()) return widths[i];
    return -1;
  endfunction

  task automatic clear_mon();
    rises.delete(); widths.delete();
    done_cnt = 0; err_cnt = 0; busy_seen = 0; done_cyc = -1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int period, input int width, input int count, input int src);
    I_cfg_period = PER_W'(period);
    I_cfg_width  = 8'(width);
    I_cfg_count  = CNT_W'(count);
    I_cfg_src    = 1'(src);
    I_cfg_wr = 1'b1;
    tick(1);
    I_cfg_wr = 1'b0;
  endtask

  task automatic do_start();
    I_start = 1'b1; tick(1); I_start = 1'b0;
  endtask

  task automatic do_stop();
    I_stop = 1'b1; tick(1); I_stop = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  int s0, e0;

  initial begin
    clear_mon();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    // Reset values.
    chk("rst_trig", O_trig, 0);
    chk("rst_busy", O_busy, 0);
    chk("rst_done", O_done, 0);
    chk("rst_err", O_cfg_err, 0);
    chk("rst_over", O_overrun, 0);
    chk("rst_cnt", O_trig_cnt, 0);
    chk("rst_state", O_state, 0);

    // Default shadows: period 1000, width 1, count 1, internal source.
    clear_mon(); s0 = cyc; do_start(); tick(6);
    chk("dflt_rise0", rise_at(0), s0 + 2);
    chk("dflt_width0", width_at(0), 1);
    chk("dflt_done_cyc", done_cyc, s0 + 3);
    chk("dflt_cnt", O_trig_cnt, 1);

    // Three internal pulses, width 2, period 10.
    clear_mon(); cfg(10, 2, 3, 0); s0 = cyc; do_start(); tick(30);
    chk("seq_rise0", rise_at(0), s0 + 2);
    chk("seq_rise1", rise_at(1), s0 + 12);
    chk("seq_rise2", rise_at(2), s0 + 22);
    chk("seq_nrise", rises.size(), 3);
    for (int i = 0; i < 3; i++) chk("seq_width", width_at(i), 2);
    chk("seq_done_cnt", done_cnt, 1);
    chk("seq_done_cyc", done_cyc, s0 + 24);
    chk("seq_cnt", O_trig_cnt, 3);
    chk("seq_busy_end", O_busy, 0);

    // Period not above width is rejected; period = width + 1 is accepted.
    clear_mon(); cfg(2, 2, 1, 0); do_start(); tick(4);
    chk("bad_err_cnt", err_cnt, 1);
    chk("bad_busy", busy_seen, 0);
    chk("bad_state", O_state, 0);
    clear_mon(); cfg(3, 2, 1, 0); do_start(); tick(8);
    chk("edge_err_cnt", err_cnt, 0);
    chk("edge_nrise", rises.size(), 1);

    // Continuous run with a busy channel across the second slot.
    clear_mon(); cfg(10, 2, 0, 0); s0 = cyc; do_start(); tick(4);
    I_ch_idle = 4'hE; tick(12);
    I_ch_idle = 4'hF; tick(3);
    chk("ovr_flag", O_overrun, 1);
    chk("ovr_rise1", rise_at(1), s0 + 18);
    chk("ovr_cnt", O_trig_cnt, 2);
    do_stop(); tick(3);
    chk("ovr_no_done", done_cnt, 0);
    chk("ovr_sticky", O_overrun, 1);

    // External source, width 0 acts as 1, two edges 50 cycles apart.
    clear_mon(); cfg(5, 0, 2, 1); do_start(); tick(3);
    e0 = cyc; I_ext_trig = 1'b1; tick(3); I_ext_trig = 1'b0; tick(47);
    I_ext_trig = 1'b1; tick(3); I_ext_trig = 1'b0; tick(10);
    chk("ext_rise0", rise_at(0), e0 + 3);
    chk("ext_rise1", rise_at(1), e0 + 53);
    chk("ext_width0", width_at(0), 1);
    chk("ext_width1", width_at(1), 1);
    chk("ext_done_cyc", done_cyc, e0 + 54);
    chk("ext_cnt", O_trig_cnt, 2);

    // Stop during a pulse, then reconfigure in IDLE.
    clear_mon(); cfg(20, 5, 0, 0); do_start(); tick(1);
    chk("stop_trig_before", O_trig, 1);
    do_stop();
    chk("stop_trig", O_trig, 0);
    chk("stop_state", O_state, 0);
    chk("stop_busy", O_busy, 0);
    tick(5);
    chk("stop_no_done", done_cnt, 0);
    clear_mon(); cfg(30, 1, 2, 0); s0 = cyc; do_start(); tick(40);
    chk("recfg_rise1", rise_at(1), s0 + 32);
    chk("recfg_done", done_cnt, 1);

    // Config write during GAP is ignored.
    clear_mon(); cfg(10, 2, 3, 0); s0 = cyc; do_start(); tick(5);
    cfg(20, 2, 3, 0); tick(30);
    chk("gapwr_rise1", rise_at(1), s0 + 12);
    chk("gapwr_rise2", rise_at(2), s0 + 22);
    chk("gapwr_done", done_cnt, 1);
    clear_mon(); s0 = cyc; do_start(); tick(30);
    chk("gapwr_keep", rise_at(1), s0 + 12);

    // Reset mid-pulse drops the trigger without a clock edge.
    cfg(10, 4, 0, 0); do_start(); tick(1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_trig", O_trig, 0);
    chk("arst_state", O_state, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    chk("arst_cnt", O_trig_cnt, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      I_cfg_wr = ($urandom_range(0, 19) == 0);
      if (I_cfg_wr) begin
        I_cfg_period = PER_W'($urandom_range(1, 30));
        I_cfg_width  = 8'($urandom_range(0, 6));
        I_cfg_count  = CNT_W'($urandom_range(0, 4));
        I_cfg_src    = 1'($urandom_range(0, 1));
      end
      I_start   = ($urandom_range(0, 14) == 0);
      I_stop    = ($urandom_range(0, 79) == 0);
      I_ch_idle = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      if ($urandom_range(0, 5) == 0) I_ext_trig = ~I_ext_trig;
      tick(1);
    end
    I_cfg_wr = 1'b0; I_start = 1'b0; I_ch_idle = 4'hF;
    do_stop(); tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
